mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares one repeated-addition multiplier datapath (A/B/P registers, B down-counter, eqz flag) between two requesters. It grants one requester, captures that requester's operands, and drives the datapath strobes LdA, LdB, LdP, clrP and decB plus the shared data bus. It returns the product with a one-cycle done pulse to the granted requester. It replaces the single-user controller wherever two clients need the multiplier.

Parameters:
WIDTH, 16, operand/product/bus width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req0  in  1  requester 0 request level
a0  in  WIDTH  requester 0 multiplicand
b0  in  WIDTH  requester 0 multiplier
req1  in  1  requester 1 request level
a1  in  WIDTH  requester 1 multiplicand
b1  in  WIDTH  requester 1 multiplier
gnt0  out  1  requester 0 owns datapath
gnt1  out  1  requester 1 owns datapath
done0  out  1  one-cycle pulse, result valid for requester 0
done1  out  1  one-cycle pulse, result valid for requester 1
result  out  WIDTH  product of last completed operation
data_bus  out  WIDTH  datapath data_in bus
LdA  out  1  load A from data_bus
LdB  out  1  load B from data_bus
LdP  out  1  P <= P + A
clrP  out  1  clear P
decB  out  1  B <= B - 1
eqz  in  1  datapath B == 0 (combinational)
p_in  in  WIDTH  datapath P register value

Behaviour:
- One clock, synchronous active-high reset. Reset drives state IDLE, all strobes, gnt*, done* and data_bus to 0, result to 0 and last-grant pointer to 1, so requester 0 wins the first tie.
- States: IDLE, LDA, LDB, RUN, DONE.
- IDLE, no strobes:
  - Only one req high: grant it.
  - Both high: grant the requester not served last.
  - On grant: latch a/b of the winner into internal op_a/op_b, set gnt, update pointer, go to LDA.
  - No req: stay in IDLE.
- LDA: data_bus=op_a, LdA=1, go to LDB.
- LDB: data_bus=op_b, LdB=1, clrP=1, go to RUN.
- RUN:
  - eqz=0: LdP=1, decB=1, stay in RUN.
  - eqz=1: no strobes, go to DONE.
- DONE:
  - result <= p_in (registered, visible from the next cycle and held until the next DONE).
  - Pulse the done of the granted requester for this cycle only. Done is combinational from state, and result is updated at this edge, so result is valid in the cycle after the done edge.
  - Clear gnt at the end of DONE, return to IDLE.
- gnt stays high from LDA through DONE inclusive. At most one gnt is high at any time.
- data_bus is 0 outside LDA/LDB.
- Operands are sampled only at the grant edge; changes to a/b afterwards are ignored.
- Handshake:
  - A requester holds req high until it sees its done, then deasserts req the next cycle.
  - req high in IDLE is always treated as a new request.
  - A req asserted during another operation waits; it is granted in the first IDLE cycle.
- Latency: grant at edge k (IDLE), LDA k+1, LDB k+2, RUN k+3..k+3+B, DONE k+4+B. Total B+5 cycles including IDLE.
- Arithmetic: result = (a*b) mod 2^WIDTH, since P wraps in the datapath.
- b=0: RUN sees eqz at once, zero LdP cycles, result 0 (from clrP).
- a=0: result 0 after B add cycles.
- Reset in any state aborts the operation: no done, gnt cleared, result cleared. A held req is re-arbitrated after reset deasserts.
- Back-to-back requests: DONE→IDLE→grant costs one IDLE cycle between operations. With both requesters continuously requesting, grants strictly alternate.

Test Plan:
- Reset, then req0 with a0=17, b0=5 → LdA with data_bus=17, next cycle LdB/clrP with data_bus=5, exactly 5 LdP/decB cycles, done0 pulse 9 cycles after the grant edge. From the next cycle, result=85 and gnt0 is low.
- req0 and req1 both high at the first IDLE after reset (a0=3,b0=4; a1=6,b1=7) → gnt0 first, result=12 with done0. Then gnt1, result=42 with done1. Never both gnt high.
- Both requesters continuously re-requesting for 4 operations → grant order 0,1,0,1.
- b0=0, a0=9 → zero LdP cycles, done0 at grant+4, result=0. Also a1=0, b1=3 → 3 LdP cycles, result=0.
- Overflow: a0=16'h0100, b0=16'h0101 → result=16'h0100 (mod 2^16).
- Assert rst during RUN of a request with b0=10 → all outputs 0 next cycle, no done0. With req0 still high after reset release, the operation restarts and completes with the correct product.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
//   Sequencer and round-robin arbiter that lets two requesters share one
//   repeated-addition multiplier datapath (A/B/P registers, B down-counter,
//   eqz flag). The winner's operands are captured at the grant edge and then
//   pushed onto the shared data bus. The controller runs the add/decrement
//   loop, then returns the product with a one-cycle done pulse.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   req0/a0/b0        : requester 0 request level and operands
//   req1/a1/b1        : requester 1 request level and operands
//   gnt0/gnt1         : requester owns the datapath (LDA through DONE)
//   done0/done1       : one-cycle completion pulse for the owner
//   result            : product of the last completed operation (registered)
//   data_bus          : datapath data_in bus, zero outside LDA/LDB
//   LdA/LdB/LdP/clrP/decB : datapath strobes
//   eqz               : datapath B == 0 (combinational)
//   p_in              : datapath P register value
module mul_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] data_bus,
  output logic             LdA,
  output logic             LdB,
  output logic             LdP,
  output logic             clrP,
  output logic             decB,
  input  logic             eqz,
  input  logic [WIDTH-1:0] p_in
);

  typedef enum logic [2:0] {
    IDLE,
    LDA,
    LDB,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             owner;      // requester holding the datapath (0 or 1)
  logic             last_gnt;   // requester served most recently
  logic             grant;
  logic             grant_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // State register plus the grant-time captures. The owner, the round-robin
  // pointer and the operands change only on the IDLE grant edge, so later
  // changes on a*/b* cannot disturb an operation in flight. The result takes
  // P on the edge leaving DONE and holds it until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        owner    <= grant_sel;
        last_gnt <= grant_sel;
        op_a     <= grant_sel ? a1 : a0;
        op_b     <= grant_sel ? b1 : b0;
      end
      if (state == DONE) begin
        result <= p_in;
      end
    end
  end

  // Next-state and strobe decode. With both requests high, the requester
  // that was not served last wins. This gives strict alternation under
  // continuous load.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    data_bus   = '0;
    LdA        = 1'b0;
    LdB        = 1'b0;
    LdP        = 1'b0;
    clrP       = 1'b0;
    decB       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          grant_sel  = (req0 && req1) ? ~last_gnt : req1;
          next_state = LDA;
        end
      end
      LDA: begin
        data_bus   = op_a;
        LdA        = 1'b1;
        next_state = LDB;
      end
      LDB: begin
        data_bus   = op_b;
        LdB        = 1'b1;
        clrP       = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        if (eqz) begin
          next_state = DONE;
        end else begin
          LdP  = 1'b1;
          decB = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant and done come straight from state and owner. As a result, reset
  // (which forces IDLE) clears them on the following cycle.
  assign gnt0  = (state != IDLE) && !owner;
  assign gnt1  = (state != IDLE) &&  owner;
  assign done0 = (state == DONE) && !owner;
  assign done1 = (state == DONE) &&  owner;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl
//   Drives mul_share_ctrl through directed and randomized requests. A small
//   behavioural datapath (A/B/P registers) answers the strobes. A reference
//   model predicts the winner, the strobe sequence and the product (a*b mod
//   2^16) of each operation.
module tb_mul_share_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1;
  logic [WIDTH-1:0] result, data_bus;
  logic             LdA, LdB, LdP, clrP, decB;
  logic             eqz;
  logic [WIDTH-1:0] p_in;

  logic [WIDTH-1:0] dp_a = '0;
  logic [WIDTH-1:0] dp_b = '0;
  logic [WIDTH-1:0] dp_p = '0;

  int total = 0;
  int bad   = 0;
  int m_last;

  mul_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .data_bus(data_bus),
    .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
    .eqz(eqz), .p_in(p_in)
  );

  always #5 clk = ~clk;

  // Shared datapath: registers loaded from the bus, with P accumulating A
  // and B counting down.
  always @(posedge clk) begin
    if (LdA) dp_a <= data_bus;
    if (LdB) dp_b <= data_bus;
    else if (decB) dp_b <= dp_b - 1'b1;
    if (clrP) dp_p <= '0;
    else if (LdP) dp_p <= dp_p + dp_a;
  end
  assign eqz  = (dp_b == '0);
  assign p_in = dp_p;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invariants that must hold in every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checkBit("one_gnt", gnt0 && gnt1, 1'b0);
      if (!LdA && !LdB) checkOutput("bus_idle", data_bus, '0);
    end
  end

  task automatic applyStimulus(input logic r0, input logic [WIDTH-1:0] aa0,
                               input logic [WIDTH-1:0] bb0, input logic r1,
                               input logic [WIDTH-1:0] aa1,
                               input logic [WIDTH-1:0] bb1);
    req0 = r0; a0 = aa0; b0 = bb0;
    req1 = r1; a1 = aa1; b1 = bb1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"},
                16'({gnt0, gnt1, done0, done1, LdA, LdB, LdP, clrP, decB}), '0);
    checkOutput({tag, "_bus"}, data_bus, '0);
    checkOutput({tag, "_result"}, result, '0);
  endtask

  // One full operation, entered at a negedge while the DUT is in IDLE with
  // requests already driven. The model picks the winner from the request
  // levels and the last-served requester, then walks the expected cycles.
  // keep=0 drops the winner's request when its done is seen.
  task automatic runOp(input bit keep);
    int               w;
    logic [WIDTH-1:0] ea, eb, ep;
    logic [31:0]      full;
    if (req0 && req1) w = (m_last == 0) ? 1 : 0;
    else if (req0)    w = 0;
    else              w = 1;
    ea     = (w == 1) ? a1 : a0;
    eb     = (w == 1) ? b1 : b0;
    full   = ea * eb;
    ep     = full[WIDTH-1:0];
    m_last = w;

    @(negedge clk);
    checkBit("lda_gnt0", gnt0, w == 0);
    checkBit("lda_gnt1", gnt1, w == 1);
    checkBit("lda_LdA", LdA, 1'b1);
    checkOutput("lda_bus", data_bus, ea);
    // Operands after the grant edge must be ignored.
    if (w == 0) begin a0 = 16'($urandom); b0 = 16'($urandom_range(0, 12)); end
    else        begin a1 = 16'($urandom); b1 = 16'($urandom_range(0, 12)); end

    @(negedge clk);
    checkBit("ldb_LdB", LdB, 1'b1);
    checkBit("ldb_clrP", clrP, 1'b1);
    checkBit("ldb_LdA", LdA, 1'b0);
    checkOutput("ldb_bus", data_bus, eb);

    for (int i = 0; i < int'(eb); i++) begin
      @(negedge clk);
      checkOutput("run_strobes", 16'({LdP, decB, done0, done1}), 16'(4'b1100));
    end

    @(negedge clk);
    checkOutput("run_exit", 16'({LdP, decB, done0, done1}), '0);

    @(negedge clk);
    checkBit("done0", done0, w == 0);
    checkBit("done1", done1, w == 1);
    checkBit("done_gnt", w == 0 ? gnt0 : gnt1, 1'b1);
    if (!keep) begin
      if (w == 0) req0 = 1'b0;
      else        req1 = 1'b0;
    end

    @(negedge clk);
    checkOutput("idle_gnt_done", 16'({gnt0, gnt1, done0, done1}), '0);
    checkOutput("result", result, ep);
  endtask

  initial begin
    rst    = 1'b1;
    m_last = 1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    checkAllZero("reset");

    // Single requester, 17*5.
    rst = 1'b0;
    applyStimulus(1'b1, 16'd17, 16'd5, 1'b0, '0, '0);
    runOp(1'b0);

    // Tie at the first IDLE after reset: requester 0 first, then 1.
    rst = 1'b1;
    m_last = 1;
    @(negedge clk);
    checkAllZero("reset2");
    rst = 1'b0;
    applyStimulus(1'b1, 16'd3, 16'd4, 1'b1, 16'd6, 16'd7);
    runOp(1'b0);
    runOp(1'b0);

    // Continuous requests from both: four alternating grants.
    applyStimulus(1'b1, 16'd11, 16'd3, 1'b1, 16'd13, 16'd2);
    for (int i = 0; i < 4; i++) runOp(1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);

    // Zero operands.
    applyStimulus(1'b1, 16'd9, 16'd0, 1'b0, '0, '0);
    runOp(1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'd0, 16'd3);
    runOp(1'b0);

    // Product wraps modulo 2^16.
    applyStimulus(1'b1, 16'h0100, 16'h0101, 1'b0, '0, '0);
    runOp(1'b0);

    // Reset during RUN aborts. The held request then restarts the operation.
    applyStimulus(1'b1, 16'd5, 16'd10, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    checkBit("pre_abort_done0", done0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("abort");
    rst    = 1'b0;
    m_last = 1;
    runOp(1'b0);

    // Randomized request patterns and operands.
    for (int n = 0; n < 10; n++) begin
      if (!req0 && ($urandom_range(0, 1) == 1)) begin
        req0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom_range(0, 12));
      end
      if (!req1 && ($urandom_range(0, 1) == 1)) begin
        req1 = 1'b1; a1 = 16'($urandom); b1 = 16'($urandom_range(0, 12));
      end
      if (!req0 && !req1) begin
        req0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom_range(0, 12));
      end
      runOp(1'b0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("final_idle", 16'({gnt0, gnt1, done0, done1}), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
